// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared types and constants for the Keccak-f round scheduler
// Purpose: scheduler state encoding, default round parameters, step ids and a
//          state-to-start-pulse decode shared with the step controllers.
// Ports:   none (package)
package keccak_pkg;

  localparam int NUM_ROUNDS_DEF = 24;
  localparam int RND_W_DEF      = 5;

  // Step ids double as bit positions in the packed start/finish vectors.
  localparam int STEP_THETA = 0;
  localparam int STEP_RHO   = 1;
  localparam int STEP_PI    = 2;
  localparam int STEP_CHI   = 3;
  localparam int STEP_IOTA  = 4;
  localparam int NUM_STEPS  = 5;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_INIT     = 4'd1,
    ST_S_THETA  = 4'd2,
    ST_W_THETA  = 4'd3,
    ST_S_RHO    = 4'd4,
    ST_W_RHO    = 4'd5,
    ST_S_PI     = 4'd6,
    ST_W_PI     = 4'd7,
    ST_S_CHI    = 4'd8,
    ST_W_CHI    = 4'd9,
    ST_S_IOTA   = 4'd10,
    ST_W_IOTA   = 4'd11,
    ST_NEXT_RND = 4'd12,
    ST_DONE     = 4'd13
  } pstate_e;

  // One-hot start vector asserted while the scheduler sits in an S_<X> state.
  function automatic logic [NUM_STEPS-1:0] step_start(input pstate_e s);
    logic [NUM_STEPS-1:0] v;
    v = '0;
    case (s)
      ST_S_THETA: v[STEP_THETA] = 1'b1;
      ST_S_RHO:   v[STEP_RHO]   = 1'b1;
      ST_S_PI:    v[STEP_PI]    = 1'b1;
      ST_S_CHI:   v[STEP_CHI]   = 1'b1;
      ST_S_IOTA:  v[STEP_IOTA]  = 1'b1;
      default:    v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/round_counter.sv
// rtl/round_counter.sv - round index counter for the Keccak-f scheduler
// Purpose: holds the current round; clears on clr_i, increments on inc_i and
//          saturates at NUM_ROUNDS-1 so it never wraps or overflows RND_W.
// Ports:   clk, rst (sync, active-high), clr_i, inc_i -> cnt_o[RND_W-1:0], last_o
module round_counter
  import keccak_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int RND_W      = RND_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [RND_W-1:0] cnt_o,
  output logic             last_o
);

  localparam logic [RND_W-1:0] LAST = RND_W'(NUM_ROUNDS - 1);

  logic [RND_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/keccak_round_scheduler.sv
// rtl/keccak_round_scheduler.sv - Keccak-f permutation step/round sequencer
// Purpose: runs theta, rho, pi, chi, iota in order for NUM_ROUNDS rounds using a
//          start-pulse/finish-pulse handshake per step unit; drives the round index
//          and the ping-pong state bank select.
// Ports:   clk, rst (sync, active-high), start_i -> busy_o, done_o,
//          round_idx_o[RND_W-1:0], bank_sel_o; per step unit <x>_start_o / <x>_finish_i
//          for x in theta, rho, pi, chi, iota.
module keccak_round_scheduler
  import keccak_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int RND_W      = RND_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [RND_W-1:0] round_idx_o,
  output logic             bank_sel_o,
  output logic             theta_start_o,
  input  logic             theta_finish_i,
  output logic             rho_start_o,
  input  logic             rho_finish_i,
  output logic             pi_start_o,
  input  logic             pi_finish_i,
  output logic             chi_start_o,
  input  logic             chi_finish_i,
  output logic             iota_start_o,
  input  logic             iota_finish_i
);

  pstate_e              state_q, state_d;
  logic                 busy_q, done_q, bank_sel_q;
  logic [NUM_STEPS-1:0] start_q;
  logic [NUM_STEPS-1:0] fin;
  logic                 bank_tgl;
  logic                 last;

  assign fin = {iota_finish_i, chi_finish_i, pi_finish_i, rho_finish_i, theta_finish_i};

  // A finish only counts in its own W state; anywhere else it is dropped unrecorded.
  always_comb begin
    state_d  = state_q;
    bank_tgl = 1'b0;
    case (state_q)
      ST_IDLE:     if (start_i) state_d = ST_INIT;
      ST_INIT:     state_d = ST_S_THETA;
      ST_S_THETA:  state_d = ST_W_THETA;
      ST_W_THETA:  if (fin[STEP_THETA]) begin state_d = ST_S_RHO;    bank_tgl = 1'b1; end
      ST_S_RHO:    state_d = ST_W_RHO;
      ST_W_RHO:    if (fin[STEP_RHO])   begin state_d = ST_S_PI;     bank_tgl = 1'b1; end
      ST_S_PI:     state_d = ST_W_PI;
      ST_W_PI:     if (fin[STEP_PI])    begin state_d = ST_S_CHI;    bank_tgl = 1'b1; end
      ST_S_CHI:    state_d = ST_W_CHI;
      ST_W_CHI:    if (fin[STEP_CHI])   begin state_d = ST_S_IOTA;   bank_tgl = 1'b1; end
      ST_S_IOTA:   state_d = ST_W_IOTA;
      ST_W_IOTA:   if (fin[STEP_IOTA])  begin state_d = ST_NEXT_RND; bank_tgl = 1'b1; end
      ST_NEXT_RND: state_d = last ? ST_DONE : ST_S_THETA;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // exactly with the state they describe without any combinational path out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      start_q    <= '0;
      bank_sel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      start_q <= step_start(state_d);
      if (state_q == ST_INIT) begin
        bank_sel_q <= 1'b0;
      end else if (bank_tgl) begin
        bank_sel_q <= ~bank_sel_q;
      end
    end
  end

  round_counter #(
    .NUM_ROUNDS(NUM_ROUNDS),
    .RND_W     (RND_W)
  ) u_round_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == ST_INIT),
    .inc_i (state_q == ST_NEXT_RND),
    .cnt_o (round_idx_o),
    .last_o(last)
  );

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign bank_sel_o    = bank_sel_q;
  assign theta_start_o = start_q[STEP_THETA];
  assign rho_start_o   = start_q[STEP_RHO];
  assign pi_start_o    = start_q[STEP_PI];
  assign chi_start_o   = start_q[STEP_CHI];
  assign iota_start_o  = start_q[STEP_IOTA];

endmodule

// File: tb/tb_keccak_round_scheduler.sv
// tb/tb_keccak_round_scheduler.sv - scoreboard bench for the Keccak-f round scheduler
module tb_keccak_round_scheduler;

  localparam int N = 24;
  localparam int BUDGET = 6000;

  typedef struct {
    int kind;   // 0..4 step id, 5 = done
    int rnd;
    int bank;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT (NUM_ROUNDS = 24)
  logic       start_i = 1'b0;
  logic       busy, done, bank_sel;
  logic [4:0] round_idx;
  logic [4:0] starts;
  logic [4:0] fins = '0;

  keccak_round_scheduler #(.NUM_ROUNDS(N), .RND_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .busy_o        (busy),
    .done_o        (done),
    .round_idx_o   (round_idx),
    .bank_sel_o    (bank_sel),
    .theta_start_o (starts[0]),
    .theta_finish_i(fins[0]),
    .rho_start_o   (starts[1]),
    .rho_finish_i  (fins[1]),
    .pi_start_o    (starts[2]),
    .pi_finish_i   (fins[2]),
    .chi_start_o   (starts[3]),
    .chi_finish_i  (fins[3]),
    .iota_start_o  (starts[4]),
    .iota_finish_i (fins[4])
  );

  // single-round DUT (NUM_ROUNDS = 1) with fixed-latency-3 stubs
  logic       start1_i = 1'b0;
  logic       busy1, done1, bank_sel1;
  logic [4:0] round_idx1;
  logic [4:0] starts1;
  logic [4:0] fins1 = '0;

  keccak_round_scheduler #(.NUM_ROUNDS(1), .RND_W(5)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start1_i),
    .busy_o        (busy1),
    .done_o        (done1),
    .round_idx_o   (round_idx1),
    .bank_sel_o    (bank_sel1),
    .theta_start_o (starts1[0]),
    .theta_finish_i(fins1[0]),
    .rho_start_o   (starts1[1]),
    .rho_finish_i  (fins1[1]),
    .pi_start_o    (starts1[2]),
    .pi_finish_i   (fins1[2]),
    .chi_start_o   (starts1[3]),
    .chi_finish_i  (fins1[3]),
    .iota_start_o  (starts1[4]),
    .iota_finish_i (fins1[4])
  );

  int   checks = 0;
  int   fails  = 0;
  exp_t exp_q[$];
  int   lat_q[$];
  int   lat_a[N*5];
  int   start_cnt = 0;
  int   done_cnt  = 0;
  int   runs      = 0;
  logic spur_en   = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    fails++;
    $display("FAIL %s: got event required none (cycle %0d)", name, cyc);
  endtask

  // Reference model: each step costs 1 + its latency, each round adds one
  // bookkeeping cycle, the first step starts two cycles after start is sampled,
  // and the bank flips once per completed step.
  task automatic plan_run(input int t0);
    int t;
    int k;
    t = t0 + 2;
    for (int r = 0; r < N; r++) begin
      for (int s = 0; s < 5; s++) begin
        k = 5 * r + s;
        exp_q.push_back('{s, r, k % 2, t});
        lat_q.push_back(lat_a[k]);
        t += 1 + lat_a[k];
      end
      t += 1;
    end
    exp_q.push_back('{5, N - 1, (5 * N) % 2, t});
    runs++;
  endtask

  task automatic fill_lat(input int lo, input int hi);
    for (int k = 0; k < N * 5; k++) lat_a[k] = $urandom_range(hi, lo);
  endtask

  task automatic wait_done(output int dcyc);
    int n;
    n = 0;
    dcyc = -1;
    while (n < BUDGET) begin
      @(negedge clk);
      if (done) begin
        dcyc = cyc;
        break;
      end
      n++;
    end
    if (dcyc < 0) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got no done required done within %0d cycles", BUDGET);
    end
  endtask

  // Stub step units: finish one latency after each start, plus optional
  // spurious rho finishes in W_THETA and in the S_RHO cycle itself.
  int fin_at[5]  = '{-1, -1, -1, -1, -1};
  int spur_cyc   = -1;
  always @(negedge clk) begin
    logic [4:0] f;
    int l;
    for (int s = 0; s < 5; s++) begin
      if (starts[s]) begin
        l = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
        fin_at[s] = cyc + l;
      end
    end
    for (int s = 0; s < 5; s++) f[s] = (fin_at[s] == cyc);
    if (spur_en) begin
      if (starts[0]) spur_cyc = cyc + 2;
      if (cyc == spur_cyc || starts[1]) f[1] = 1'b1;
    end
    fins = f;
  end

  // Monitor: pops the scoreboard whenever the DUT shows a step start or done.
  logic prev_any = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    int   sid;
    if (!rst) begin
      if (|starts) begin
        start_cnt++;
        sid = -1;
        for (int s = 4; s >= 0; s--) if (starts[s]) sid = s;
        check("start_onehot", $countones(starts), 1);
        check("start_width", int'(prev_any), 0);
        check("busy_at_start", int'(busy), 1);
        if (exp_q.size() == 0) begin
          fail_event("unexpected_start");
        end else begin
          e = exp_q.pop_front();
          check("step_order", sid, e.kind);
          check("start_round_idx", int'(round_idx), e.rnd);
          check("start_bank_sel", int'(bank_sel), e.bank);
          check("start_cycle", cyc, e.cyc);
        end
      end
      if (done) begin
        done_cnt++;
        check("busy_at_done", int'(busy), 1);
        if (exp_q.size() == 0) begin
          fail_event("unexpected_done");
        end else begin
          e = exp_q.pop_front();
          check("done_order", 5, e.kind);
          check("done_round_idx", int'(round_idx), e.rnd);
          check("done_bank_sel", int'(bank_sel), e.bank);
          check("done_cycle", cyc, e.cyc);
        end
      end
    end
    prev_any = |starts;
  end

  // Single-round stub: finish arrives exactly three cycles after its start.
  logic [4:0] h1 = '0, h2 = '0, h3 = '0;
  always @(negedge clk) begin
    fins1 = h3;
    h3 = h2;
    h2 = h1;
    h1 = starts1;
  end

  int d, t0, sc0, hit;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_round_idx", int'(round_idx), 0);
    check("rst_bank_sel", int'(bank_sel), 0);
    check("rst_starts", int'(starts), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // all latencies 1: 266-cycle permutation, 120 starts
    fill_lat(1, 1);
    sc0 = start_cnt;
    start_i = 1'b1;
    t0 = cyc;
    plan_run(t0);
    @(negedge clk);
    start_i = 1'b0;
    wait_done(d);
    check("l1_latency", d - t0, 266);
    check("l1_start_count", start_cnt - sc0, 120);
    @(negedge clk);
    check("l1_busy_after_done", int'(busy), 0);
    repeat (3) @(negedge clk);

    // spurious rho finishes with latency 4
    fill_lat(4, 4);
    spur_en = 1'b1;
    start_i = 1'b1;
    plan_run(cyc);
    @(negedge clk);
    start_i = 1'b0;
    wait_done(d);
    spur_en = 1'b0;
    repeat (3) @(negedge clk);

    // start held high across two permutations
    fill_lat(2, 2);
    start_i = 1'b1;
    plan_run(cyc);
    wait_done(d);
    @(negedge clk);
    check("held_idle_after_done", int'(busy), 0);
    plan_run(cyc);
    repeat (2) @(negedge clk);
    start_i = 1'b0;
    wait_done(d);
    repeat (6) @(negedge clk);
    check("held_busy_idle", int'(busy), 0);

    // reset inside W_CHI of round 7, stale chi finish afterwards
    fill_lat(6, 6);
    start_i = 1'b1;
    plan_run(cyc);
    @(negedge clk);
    start_i = 1'b0;
    hit = 0;
    for (int n = 0; n < BUDGET && hit == 0; n++) begin
      @(negedge clk);
      if (starts[3] && round_idx == 5'd7) hit = 1;
    end
    check("reach_chi_round7", hit, 1);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    runs--;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_round_idx", int'(round_idx), 0);
    check("mid_rst_bank_sel", int'(bank_sel), 0);
    check("mid_rst_starts", int'(starts), 0);
    check("mid_rst_done", int'(done), 0);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("stale_finish_ignored", int'(busy), 0);
    end
    done_cnt = 0;
    runs = 0;

    // random latencies 1..8
    for (int r = 0; r < 3; r++) begin
      fill_lat(1, 8);
      start_i = 1'b1;
      plan_run(cyc);
      @(negedge clk);
      start_i = 1'b0;
      wait_done(d);
      repeat ($urandom_range(3, 1)) @(negedge clk);
    end
    check("done_count", done_cnt, runs);
    check("scoreboard_drained", exp_q.size(), 0);

    // single round, latency 3: done 23 cycles after start
    start1_i = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start1_i = 1'b0;
    d = -1;
    for (int n = 0; n < 200 && d < 0; n++) begin
      @(negedge clk);
      if (done1) d = cyc;
    end
    check("n1_latency", d - t0, 23);
    check("n1_bank_sel", int'(bank_sel1), 1);
    check("n1_round_idx", int'(round_idx1), 0);
    check("n1_busy_at_done", int'(busy1), 1);
    @(negedge clk);
    check("n1_busy_after_done", int'(busy1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
